jtframe_rst_seq: RTL and testbench

// Parametrised reset supervisor for jtframe platform tops. Watches PLL lock, pulses the PLL reset on lock loss,

---
 rtl/jtframe_rst_seq_pkg.sv | 23 ++
 rtl/jtframe_rst_seq_if.sv | 26 ++
 rtl/jtframe_rst_seq_sync2.sv | 22 ++
 rtl/jtframe_rst_seq.sv | 166 ++++++++++++++++
 tb/tb_jtframe_rst_seq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/jtframe_rst_seq_pkg.sv
// Shared constants for the jtframe reset supervisor: FSM encoding and default timing.
package jtframe_rst_pkg;

    localparam int DEF_NOUT     = 3;
    localparam int DEF_CW       = 8;
    localparam int DEF_PLL_HOLD = 255;
    localparam int DEF_LOCK_MIN = 208;
    localparam int DEF_GAP      = 16;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_PLLRST    = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_RELEASE   = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;

    // True when a timing constant is usable by a CW-bit counter compared with ==.
    function automatic bit fits_cw(input int value, input int cw);
        return (value >= 1) && (longint'(value) <= ((longint'(1) << cw) - 1));
    endfunction

endpackage

// File: rtl/jtframe_rst_seq_if.sv
// Reset-supervisor bundle: PLL/request inputs and staged reset outputs of one platform top.
interface jtframe_rst_seq_if
    import jtframe_rst_pkg::*;
#(
    parameter int NOUT = DEF_NOUT,
    parameter int CW   = DEF_CW
);
    logic            pll_locked;
    logic            rst_req;
    logic            downloading;
    logic            pll_rst;
    logic [NOUT-1:0] rst;
    logic            game_rst;
    logic            busy;
    logic [CW-1:0]   lock_loss;

    modport master (
        input  pll_locked, rst_req, downloading,
        output pll_rst, rst, game_rst, busy, lock_loss
    );

    modport slave (
        output pll_locked, rst_req, downloading,
        input  pll_rst, rst, game_rst, busy, lock_loss
    );
endinterface

// File: rtl/jtframe_rst_seq_sync2.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module jtframe_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/jtframe_rst_seq.sv
// Reset supervisor: pulses the PLL reset on lock loss, then releases NOUT reset stages
// in order once lock has been stable; user requests and ROM download gating are merged here.
module jtframe_rst_seq
    import jtframe_rst_pkg::*;
#(
    parameter int NOUT     = DEF_NOUT,
    parameter int CW       = DEF_CW,
    parameter int PLL_HOLD = DEF_PLL_HOLD,
    parameter int LOCK_MIN = DEF_LOCK_MIN,
    parameter int GAP      = DEF_GAP
) (
    input  logic clk,
    input  logic rst_n,
    jtframe_rst_seq_if.master bus
);
    localparam int SW = $clog2(NOUT + 1);

    localparam logic [CW-1:0] HOLD_LAST  = CW'(PLL_HOLD - 1);
    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_MIN - 1);
    localparam logic [CW-1:0] GAP_CNT    = CW'(GAP);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NOUT - 1);

    if ((NOUT < 1) || (NOUT > 8) || !fits_cw(PLL_HOLD, CW) ||
        !fits_cw(LOCK_MIN, CW) || !fits_cw(GAP, CW)) begin : g_param_err
        $error("jtframe_rst_seq: NOUT must be 1..8 and PLL_HOLD/LOCK_MIN/GAP must be 1..2^CW-1");
    end

    logic            w_lk;
    logic            r_lk_d;
    logic            w_loss;
    logic            w_req_ok;
    logic            w_clear_now;
    logic [NOUT-1:0] w_clr_mask;

    logic [2:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [SW-1:0]   r_stage;
    logic            r_pll_rst;
    logic [NOUT-1:0] r_rst;
    logic            r_game_rst;
    logic [CW-1:0]   r_lock_loss;

    jtframe_sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.pll_locked),
        .o_q   (w_lk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lk_d <= 1'b0;
        else        r_lk_d <= w_lk;
    end

    assign w_loss = r_lk_d & ~w_lk;

    // Requests are ignored while the PLL itself is being reset; HOLD handles its own exit.
    assign w_req_ok = bus.rst_req &&
                      ((r_state == ST_WAIT_LOCK) || (r_state == ST_RELEASE) || (r_state == ST_RUN));

    // First clear happens on the RELEASE entry cycle, later ones every GAP cycles.
    assign w_clear_now = (r_cnt == '0) || (r_cnt == GAP_CNT);

    for (genvar gi = 0; gi < NOUT; gi++) begin : g_clr_mask
        assign w_clr_mask[gi] = (r_stage == SW'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_WAIT_LOCK;
            r_cnt     <= '0;
            r_stage   <= '0;
            r_pll_rst <= 1'b0;
            r_rst     <= '1;
        end else if (w_loss) begin
            r_state   <= ST_PLLRST;
            r_cnt     <= '0;
            r_stage   <= '0;
            r_pll_rst <= 1'b1;
            r_rst     <= '1;
        end else if (w_req_ok) begin
            r_state   <= ST_HOLD;
            r_cnt     <= '0;
            r_stage   <= '0;
            r_pll_rst <= 1'b0;
            r_rst     <= '1;
        end else begin
            case (r_state)
                ST_PLLRST: begin
                    r_rst <= '1;
                    if (r_cnt == HOLD_LAST) begin
                        r_pll_rst <= 1'b0;
                        r_state   <= ST_WAIT_LOCK;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    r_rst <= '1;
                    if (!w_lk) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LOCK_LAST) begin
                        r_state <= ST_RELEASE;
                        r_cnt   <= '0;
                        r_stage <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (w_clear_now) begin
                        r_rst <= r_rst & ~w_clr_mask;
                        if (r_stage == LAST_STAGE) begin
                            r_state <= ST_RUN;
                            r_cnt   <= '0;
                        end else begin
                            r_stage <= r_stage + SW'(1);
                            r_cnt   <= CW'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_RUN: begin
                    r_rst <= '0;
                end
                ST_HOLD: begin
                    r_rst <= '1;
                    if (!bus.rst_req) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state   <= ST_WAIT_LOCK;
                    r_cnt     <= '0;
                    r_stage   <= '0;
                    r_pll_rst <= 1'b0;
                    r_rst     <= '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_loss <= '0;
        end else if (w_loss && (r_lock_loss != {CW{1'b1}})) begin
            r_lock_loss <= r_lock_loss + CW'(1);
        end
    end

    // Download gating only touches the game core reset, never the sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_game_rst <= 1'b1;
        else        r_game_rst <= r_rst[NOUT-1] | bus.downloading;
    end

    assign bus.pll_rst   = r_pll_rst;
    assign bus.rst       = r_rst;
    assign bus.game_rst  = r_game_rst;
    assign bus.busy      = (r_state != ST_RUN);
    assign bus.lock_loss = r_lock_loss;

endmodule

// File: tb/tb_jtframe_rst_seq.sv
// Directed bench: default-sized supervisor plus a tiny NOUT=1, CW=4 instance for saturation.
module tb_jtframe_rst_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   exp_ll;

    jtframe_rst_seq_if #(.NOUT(3), .CW(8)) bus0 ();
    jtframe_rst_seq_if #(.NOUT(1), .CW(4)) bus1 ();

    jtframe_rst_seq #(
        .NOUT(3), .CW(8), .PLL_HOLD(255), .LOCK_MIN(208), .GAP(16)
    ) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    jtframe_rst_seq #(
        .NOUT(1), .CW(4), .PLL_HOLD(3), .LOCK_MIN(4), .GAP(2)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus0.pll_locked  = 1'b1;
        bus0.rst_req     = 1'b0;
        bus0.downloading = 1'b0;
        bus1.pll_locked  = 1'b1;
        bus1.rst_req     = 1'b0;
        bus1.downloading = 1'b0;

        tick(3);
        check("reset_rst",       32'(bus0.rst), 32'h7);
        check("reset_pll_rst",   32'(bus0.pll_rst), 32'h0);
        check("reset_game_rst",  32'(bus0.game_rst), 32'h1);
        check("reset_busy",      32'(bus0.busy), 32'h1);
        check("reset_lock_loss", 32'(bus0.lock_loss), 32'h0);

        // Power-up release: lock seen after 2 edges, 208 stable cycles, then stages.
        rst_n = 1'b1;
        tick(210);
        check("boot_pre_release", 32'(bus0.rst), 32'h7);
        tick(1);
        check("boot_stage0",      32'(bus0.rst), 32'h6);
        tick(15);
        check("boot_gap_hold",    32'(bus0.rst), 32'h6);
        tick(1);
        check("boot_stage1",      32'(bus0.rst), 32'h4);
        tick(15);
        check("boot_stage1_hold", 32'(bus0.rst), 32'h4);
        check("boot_busy_hold",   32'(bus0.busy), 32'h1);
        tick(1);
        check("boot_stage2",      32'(bus0.rst), 32'h0);
        check("boot_busy_fall",   32'(bus0.busy), 32'h0);
        tick(2);
        check("boot_game_rst",    32'(bus0.game_rst), 32'h0);

        // Download gating in RUN.
        bus0.downloading = 1'b1;
        check("dl_not_yet",       32'(bus0.game_rst), 32'h0);
        tick(1);
        check("dl_game_rst_on",   32'(bus0.game_rst), 32'h1);
        tick(5);
        check("dl_rst_untouched", 32'(bus0.rst), 32'h0);
        check("dl_busy",          32'(bus0.busy), 32'h0);
        bus0.downloading = 1'b0;
        tick(1);
        check("dl_game_rst_off",  32'(bus0.game_rst), 32'h0);

        // 3-cycle reset request in RUN, then a full lock window and release.
        bus0.rst_req = 1'b1;
        tick(1);
        check("req_assert",      32'(bus0.rst), 32'h7);
        check("req_busy",        32'(bus0.busy), 32'h1);
        tick(2);
        bus0.rst_req = 1'b0;
        tick(209);
        check("req_window_hold", 32'(bus0.rst), 32'h7);
        tick(1);
        check("req_stage0",      32'(bus0.rst), 32'h6);
        tick(32);
        check("req_run",         32'(bus0.rst), 32'h0);

        // Lock loss in RUN for 5 cycles.
        bus0.pll_locked = 1'b0;
        tick(2);
        check("loss_rst_pre",    32'(bus0.rst), 32'h0);
        check("loss_pll_pre",    32'(bus0.pll_rst), 32'h0);
        tick(1);
        check("loss_rst",        32'(bus0.rst), 32'h7);
        check("loss_pll_rst",    32'(bus0.pll_rst), 32'h1);
        check("loss_count1",     32'(bus0.lock_loss), 32'h1);
        tick(2);
        bus0.pll_locked = 1'b1;
        tick(252);
        check("loss_pll_last",   32'(bus0.pll_rst), 32'h1);
        tick(1);
        check("loss_pll_end",    32'(bus0.pll_rst), 32'h0);
        check("loss_rst_wait",   32'(bus0.rst), 32'h7);
        tick(208);
        check("loss_window",     32'(bus0.rst), 32'h7);
        tick(1);
        check("loss_stage0",     32'(bus0.rst), 32'h6);
        tick(32);
        check("loss_run_rst",    32'(bus0.rst), 32'h0);
        check("loss_run_busy",   32'(bus0.busy), 32'h0);

        // Lock toggling 100/100: each drop restarts PLLRST, nothing is released.
        for (int i = 0; i < 4; i++) begin
            bus0.pll_locked = 1'b0;
            tick(100);
            check("toggle_rst_lo",  32'(bus0.rst), 32'h7);
            check("toggle_pll_lo",  32'(bus0.pll_rst), 32'h1);
            check("toggle_count",   32'(bus0.lock_loss), 32'(2 + i));
            bus0.pll_locked = 1'b1;
            tick(100);
            check("toggle_rst_hi",  32'(bus0.rst), 32'h7);
            check("toggle_pll_hi",  32'(bus0.pll_rst), 32'h1);
        end
        check("toggle_total", 32'(bus0.lock_loss), 32'h5);
        tick(266);
        check("toggle_window", 32'(bus0.rst), 32'h7);
        tick(1);
        check("toggle_stage0", 32'(bus0.rst), 32'h6);

        // rst_n pulse in the middle of RELEASE: everything back to reset values at once.
        tick(5);
        rst_n = 1'b0;
        #1;
        check("arst_rst",       32'(bus0.rst), 32'h7);
        check("arst_pll_rst",   32'(bus0.pll_rst), 32'h0);
        check("arst_game_rst",  32'(bus0.game_rst), 32'h1);
        check("arst_busy",      32'(bus0.busy), 32'h1);
        check("arst_lock_loss", 32'(bus0.lock_loss), 32'h0);
        check("arst_rst1",      32'(bus1.rst), 32'h1);
        tick(1);
        rst_n = 1'b1;

        // NOUT=1 instance: lock at edge 2, 4 stable cycles, RELEASE then RUN next cycle.
        tick(6);
        check("n1_release_entry", 32'(bus1.rst), 32'h1);
        check("n1_busy_entry",    32'(bus1.busy), 32'h1);
        tick(1);
        check("n1_run_rst",       32'(bus1.rst), 32'h0);
        check("n1_run_busy",      32'(bus1.busy), 32'h0);

        // 20 lock losses into a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            bus1.pll_locked = 1'b0;
            tick(4);
            exp_ll = (i + 1 > 15) ? 15 : i + 1;
            check("sat_count", 32'(bus1.lock_loss), 32'(exp_ll));
            check("sat_rst",   32'(bus1.rst), 32'h1);
            bus1.pll_locked = 1'b1;
            tick(4);
        end
        tick(20);
        check("sat_run_rst",  32'(bus1.rst), 32'h0);
        check("sat_run_busy", 32'(bus1.busy), 32'h0);

        // rst_req raised during PLLRST is held off, then honoured in WAIT_LOCK.
        bus1.pll_locked = 1'b0;
        tick(1);
        bus1.pll_locked = 1'b1;
        tick(2);
        check("preq_pll_rst", 32'(bus1.pll_rst), 32'h1);
        check("preq_sat",     32'(bus1.lock_loss), 32'hF);
        bus1.rst_req = 1'b1;
        tick(2);
        check("preq_pll_hold", 32'(bus1.pll_rst), 32'h1);
        tick(1);
        check("preq_pll_end",  32'(bus1.pll_rst), 32'h0);
        tick(4);
        check("preq_hold_rst",  32'(bus1.rst), 32'h1);
        check("preq_hold_busy", 32'(bus1.busy), 32'h1);
        bus1.rst_req = 1'b0;
        tick(5);
        check("preq_window",   32'(bus1.rst), 32'h1);
        tick(1);
        check("preq_release",  32'(bus1.rst), 32'h0);
        check("preq_run_busy", 32'(bus1.busy), 32'h0);
        tick(2);
        check("preq_game_rst", 32'(bus1.game_rst), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
